// File: rtl/alu_share_arb_if.sv
// Bundle of the requester, shared-ALU and response-slot signals around alu_share_arb.
// The arbiter connects through the slave modport; requesters/consumer/ALU sit on the master side.
interface alu_share_arb_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_instr;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_instr;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic [31:0]      alu_instr;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic [2:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_port;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  logic [2:0]       rsp_flags;

  modport slave (
    input  req0_valid, req0_instr, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_instr, req1_a, req1_b, req1_tag,
    output req1_ready,
    output alu_instr, alu_a, alu_b,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_port, rsp_tag, rsp_result, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_instr, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_instr, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  alu_instr, alu_a, alu_b,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_port, rsp_tag, rsp_result, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response slot under valid/ready backpressure.
module alu_share_arb #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_arb_if.slave   bus,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic             dbg_state,
  output logic             dbg_prio
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Requesters hold their fields while valid & !ready; ready is combinational from
  // both valids and rsp_ready, so valid must never depend on ready.

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q;
  logic             gnt0, gnt1, accept, can_issue, sel;
  logic             rsp_port_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [31:0]      rsp_result_q;
  logic [2:0]       rsp_flags_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  assign can_issue = (state_q == ST_EMPTY) || bus.rsp_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && can_issue) begin
      if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept = gnt0 | gnt1;
  // Idle cycles still steer the ALU from the preferred port; the result is simply unused.
  assign sel    = accept ? gnt1 : prio_q;

  always_comb begin
    bus.alu_instr = bus.req0_instr;
    bus.alu_a     = bus.req0_a;
    bus.alu_b     = bus.req0_b;
    if (sel) begin
      bus.alu_instr = bus.req1_instr;
      bus.alu_a     = bus.req1_a;
      bus.alu_b     = bus.req1_b;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)             state_d = ST_FULL;
        else if (bus.rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      prio_q       <= 1'b0;
      rsp_port_q   <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= bus.alu_flags;
        rsp_port_q   <= gnt1;
        rsp_tag_q    <= gnt1 ? bus.req1_tag : bus.req0_tag;
        prio_q       <= ~gnt1;
        if (gnt0) cnt0_q <= cnt0_q + CNT_W'(1);
        if (gnt1) cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = (state_q == ST_FULL);
  assign bus.rsp_port   = rsp_port_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign gnt_cnt0       = cnt0_q;
  assign gnt_cnt1       = cnt1_q;
  assign dbg_state      = state_q;
  assign dbg_prio       = prio_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vectors, expected responses queued at issue time
// and compared by an independent monitor whenever a response is consumed.
module tb_alu_share_arb;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
  logic             dbg_state, dbg_prio;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;
  logic [31:0] alu_r;
  logic        alu_ovf;

  alu_share_arb_if #(.TAG_W(TAG_W)) bus ();

  alu_share_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .dbg_state (dbg_state),
    .dbg_prio  (dbg_prio)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Stand-in for the external ALU; "negative" is the sign of the true (unwrapped) result.
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (bus.alu_instr[5:0])
      6'h20: begin
        alu_r   = bus.alu_a + bus.alu_b;
        alu_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
      end
      6'h22: begin
        alu_r   = bus.alu_a - bus.alu_b;
        alu_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (alu_r[31] != bus.alu_a[31]);
      end
      6'h24:   alu_r = bus.alu_a & bus.alu_b;
      6'h25:   alu_r = bus.alu_a | bus.alu_b;
      default: alu_r = '0;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_flags  = {alu_r == 32'h0, alu_r[31] ^ alu_ovf, alu_ovf};

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_instr = instr; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_instr = instr; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
    end
  endtask

  task automatic push(input logic p, input logic [3:0] tag, input logic [31:0] res, input logic [2:0] fl);
    exp_q.push_back({p, tag, res, fl});
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      samp();
      #1;
      if (exp_q.size() == 0 && !bus.rsp_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses rsp_valid=%b, required 0 and 0",
               exp_q.size(), bus.rsp_valid);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got port %0d tag %h result %h flags %b, required no response",
                   bus.rsp_port, bus.rsp_tag, bus.rsp_result, bus.rsp_flags);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.rsp_port, bus.rsp_tag, bus.rsp_result, bus.rsp_flags} !== mon_e) begin
            errors++;
            $display("FAIL rsp_data: got port %0d tag %h result %h flags %b, required port %0d tag %h result %h flags %b",
                     bus.rsp_port, bus.rsp_tag, bus.rsp_result, bus.rsp_flags,
                     mon_e[39], mon_e[38:35], mon_e[34:3], mon_e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    set_req(0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) next();
    rst_n = 1'b1;
    samp();
    chk("reset_rsp_valid",  bus.rsp_valid,  0);
    chk("reset_rsp_port",   bus.rsp_port,   0);
    chk("reset_rsp_tag",    bus.rsp_tag,    0);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_rsp_flags",  bus.rsp_flags,  0);
    chk("reset_cnt0",       gnt_cnt0,       0);
    chk("reset_cnt1",       gnt_cnt1,       0);
    chk("reset_prio",       dbg_prio,       0);
    chk("reset_state",      dbg_state,      0);

    // single add with signed overflow
    next();
    set_req(0, 1'b1, 32'h00000020, 32'h7FFFFFFF, 32'h1, 4'h3);
    push(1'b0, 4'h3, 32'h80000000, 3'b001);
    samp();
    chk("add_req0_ready", bus.req0_ready, 1);
    chk("add_req1_ready", bus.req1_ready, 0);
    next();
    set_req(0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    samp();
    chk("add_latency_valid", bus.rsp_valid, 1);
    chk("add_result",        bus.rsp_result, 32'h80000000);
    chk("add_cnt0",          gnt_cnt0, 1);
    chk("add_prio",          dbg_prio, 1);
    next();
    drain();

    // backpressure: port1 sub held while rsp_ready=0, port0 request pending
    next();
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'h00000022, 32'h5, 32'h5, 4'h2);
    push(1'b1, 4'h2, 32'h0, 3'b100);
    samp();
    chk("bp_req1_ready", bus.req1_ready, 1);
    next();
    set_req(1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    set_req(0, 1'b1, 32'h00000024, 32'hF0F0F0F0, 32'hFF00FF00, 4'h4);
    push(1'b0, 4'h4, 32'hF000F000, 3'b010);
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("bp_rsp_valid",  bus.rsp_valid,  1);
      chk("bp_rsp_result", bus.rsp_result, 0);
      chk("bp_rsp_flags",  bus.rsp_flags,  3'b100);
      chk("bp_rsp_tag",    bus.rsp_tag,    4'h2);
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_req1_ready", bus.req1_ready, 0);
      next();
    end
    bus.rsp_ready = 1'b1;
    samp();
    chk("bp_release_req0_ready", bus.req0_ready, 1);

    // full slot drained and reloaded in the same cycle
    next();
    set_req(0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h00000025, 32'h00000012, 32'h00000300, 4'h6);
    push(1'b1, 4'h6, 32'h00000312, 3'b000);
    samp();
    chk("reload_rsp_valid", bus.rsp_valid, 1);
    chk("reload_rsp_port",  bus.rsp_port,  0);
    chk("reload_req1_ready", bus.req1_ready, 1);
    next();
    set_req(1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    samp();
    chk("nobubble_rsp_valid",  bus.rsp_valid,  1);
    chk("nobubble_rsp_port",   bus.rsp_port,   1);
    chk("nobubble_rsp_result", bus.rsp_result, 32'h00000312);
    next();
    drain();
    chk("bp_cnt0", gnt_cnt0, 2);
    chk("bp_cnt1", gnt_cnt1, 2);
    chk("bp_prio", dbg_prio, 0);

    // contention: both ports valid for 6 cycles
    next();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h00000020, 32'h2, 32'h3, 4'h5);
    set_req(1, 1'b1, 32'h00000022, 32'h3, 32'hA, 4'h9);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 4'h5, 32'h00000005, 3'b000);
      push(1'b1, 4'h9, 32'hFFFFFFF9, 3'b010);
    end
    for (int i = 0; i < 6; i++) begin
      samp();
      chk("rr_req0_ready", bus.req0_ready, (i % 2) == 0);
      chk("rr_req1_ready", bus.req1_ready, (i % 2) == 1);
      next();
    end
    drain();
    chk("rr_cnt0", gnt_cnt0, 5);
    chk("rr_cnt1", gnt_cnt1, 5);

    // reset while a response is pending and both ports request
    next();
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h00000020, 32'h1, 32'h1, 4'hA);
    set_req(1, 1'b1, 32'h00000020, 32'h2, 32'h2, 4'hB);
    samp();
    chk("mid_req0_ready", bus.req0_ready, 1);
    next();
    samp();
    chk("mid_rsp_valid", bus.rsp_valid, 1);
    next();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    samp();
    chk("inrst_req0_ready", bus.req0_ready, 0);
    chk("inrst_req1_ready", bus.req1_ready, 0);
    next();
    rst_n = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    samp();
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_cnt0",      gnt_cnt0, 0);
    chk("mid_rst_cnt1",      gnt_cnt1, 0);
    chk("mid_rst_prio",      dbg_prio, 0);
    chk("mid_rst_tag",       bus.rsp_tag, 0);
    next();
    drain();

    // counter wrap: 17 back-to-back accepts on port 0 with a 4-bit counter
    next();
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      set_req(0, 1'b1, 32'h00000020, 32'(k), 32'(k), 4'(k));
      push(1'b0, 4'(k), 32'(2 * k), 3'b000);
      next();
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    drain();
    chk("wrap_cnt0", gnt_cnt0, 1);
    chk("wrap_cnt1", gnt_cnt1, 0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and issue controller that shares the single combinational 32-bit MIPS ALU between two requesters (e.g. the main EX stage and a branch/address helper). It selects one request per cycle by round-robin, drives the shared ALU, and registers the result and flags into a one-entry response slot with valid/ready backpressure. It sits between the requesters and the ALU instance; the ALU itself stays outside this block.

## Interface

- TAG_W, 4, width of the requester-supplied tag returned with each response
- CNT_W, 16, width of the per-port grant counters
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  grant; accept happens on valid & ready at the clock edge
- req0_instr / req1_instr  in  32  MIPS instruction word for the ALU
- req0_a, req0_b / req1_a, req1_b  in  32  operands (regA, regB)
- req0_tag / req1_tag  in  TAG_W  opaque tag
- alu_instr, alu_a, alu_b  out  32  drive the shared ALU
- alu_result  in  32  ALU result (combinational from alu_* outputs)
- alu_flags  in  3  ALU flags {zero, negative, overflow}
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_port  out  1  port that issued the response
- rsp_tag  out  TAG_W  tag of the issuing request
- rsp_result  out  32  captured alu_result
- rsp_flags  out  3  captured alu_flags
- gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted-request counts per port

## Operation

- State: rsp slot EMPTY (rsp_valid=0) or FULL (rsp_valid=1); round-robin pointer prio (0 = port 0 preferred).
- can_issue = !rsp_valid | rsp_ready.
- Grant when can_issue: one valid port -> that port; both valid -> port prio. No grant when !can_issue.
- reqN_ready = grant to N. Never both high. Forced 0 while rst_n=0.
- alu_instr/alu_a/alu_b = granted port's fields; with no grant, port prio's fields (no functional effect).
- On accept: rsp_result/rsp_flags <= alu_result/alu_flags; rsp_port, rsp_tag <= granted port/tag; rsp_valid <= 1; prio <= ~granted port; gnt_cntN increments, wrapping modulo 2^CNT_W.
- rsp_valid & rsp_ready with no new accept: rsp_valid <= 0. Both events in one cycle: slot reloads, rsp_valid stays 1.
- prio changes only on an accept.
- Flags are passed through unmodified; this block does not interpret them.
- Requesters hold instr/a/b/tag stable while valid & !ready; reqN_valid must not depend on reqN_ready (ready depends combinationally on both valids and rsp_ready).

## Timing

- Reset (rst_n low at an edge): rsp_valid=0, prio=0, gnt_cnt0=gnt_cnt1=0; rsp_port=0, rsp_tag=0, rsp_result=0, rsp_flags=0. Reset mid-transaction discards a pending response; no response is ever produced for it.
- Latency: accept at edge T -> rsp_valid=1 with data valid after edge T, i.e. in cycle T+1.
- Throughput: 1 response/cycle with rsp_ready held high.
- rsp_* stable while rsp_valid & !rsp_ready.
- Contention with both ports valid and rsp_ready=1: grants alternate 0,1,0,1... Neither port waits more than 1 grant.

## Test plan

- Reset then single add: req0 instr=32'h00000020, a=32'h7FFFFFFF, b=1, tag=3 -> next cycle rsp_valid=1, rsp_port=0, rsp_tag=3, rsp_result=32'h80000000, rsp_flags=3'b001, gnt_cnt0=1.
- Contention: both ports valid for 6 cycles, rsp_ready=1 -> grant order 0,1,0,1,0,1, gnt_cnt0=gnt_cnt1=3.
- Backpressure: port1 sub instr=32'h00000022, a=b=5 accepted; rsp_ready=0 for 4 cycles -> rsp_result=0, rsp_flags=3'b100 held stable, req0_ready=req1_ready=0 throughout; rsp_ready=1 -> pending request accepted same cycle, rsp_valid stays 1.
- Simultaneous drain and accept: FULL slot, rsp_ready=1, req1 valid -> rsp_valid stays 1, new data next cycle, no bubble.
- Reset mid-operation: rst_n low while rsp_valid=1 and both ports valid -> after the edge rsp_valid=0, both readies 0, counters 0, prio=0.
- Counter wrap (CNT_W=4): 17 accepts on port 0 -> gnt_cnt0=1.
